// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU control decoder.
// Holds the ALUOp and opcode encodings, the ALU control codes, the
// pipeline state encoding and the decode result record.
package alu_pkg;

   localparam int ALU_OPC_W   = 4;
   localparam int ALU_FUNCT_W = 2;
   localparam int ALU_CTRL_W  = 4;
   localparam int ALU_SHAMT_W = 4;

   // ALUOp field encodings
   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   // Opcodes that select a row of the decode table
   localparam logic [ALU_OPC_W-1:0] OPC_R_LOGIC = 4'b0000;
   localparam logic [ALU_OPC_W-1:0] OPC_R_ARITH = 4'b0001;
   localparam logic [ALU_OPC_W-1:0] OPC_R_SHIFT = 4'b0010;
   localparam logic [ALU_OPC_W-1:0] OPC_ADDI    = 4'b1001;
   localparam logic [ALU_OPC_W-1:0] OPC_SUBI    = 4'b1010;
   localparam logic [ALU_OPC_W-1:0] OPC_SLTI    = 4'b1011;

   // ALU control codes
   localparam logic [ALU_CTRL_W-1:0] CTRL_AND  = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] CTRL_OR   = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] CTRL_XOR  = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] CTRL_ADD  = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] CTRL_SUB  = 4'b1100;
   localparam logic [ALU_CTRL_W-1:0] CTRL_SLL  = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] CTRL_SRA  = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] CTRL_ADDI = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] CTRL_SUBI = 4'b1101;
   localparam logic [ALU_CTRL_W-1:0] CTRL_SLTI = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SINGLE = 2'b01,
      ST_SHIFT  = 2'b10
   } state_e;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] ctrl;
      logic                  illegal;
      logic                  is_shift;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: purely combinational ALU control table.
// Ports: ALUOp/opcode/Funct in; dec_o = {ctrl, illegal, is_shift} out.
// Unlisted combinations decode to ctrl 0000 with illegal set.
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter int OPC_W   = ALU_OPC_W,
   parameter int FUNCT_W = ALU_FUNCT_W
) (
   input  logic [1:0]         ALUOp,
   input  logic [OPC_W-1:0]   opcode,
   input  logic [FUNCT_W-1:0] Funct,
   output dec_t               dec_o
);

   // Table lookup; illegal is the default outcome
   always_comb begin
      dec_o.ctrl     = CTRL_AND;
      dec_o.illegal  = 1'b1;
      dec_o.is_shift = 1'b0;
      case (ALUOp)
         ALUOP_MEM: begin dec_o.ctrl = CTRL_ADD; dec_o.illegal = 1'b0; end
         ALUOP_BR:  begin dec_o.ctrl = CTRL_SUB; dec_o.illegal = 1'b0; end
         ALUOP_R: begin
            case ({opcode, Funct})
               {OPC_R_LOGIC, 2'b00}: begin dec_o.ctrl = CTRL_AND; dec_o.illegal = 1'b0; end
               {OPC_R_LOGIC, 2'b01}: begin dec_o.ctrl = CTRL_OR;  dec_o.illegal = 1'b0; end
               {OPC_R_LOGIC, 2'b10}: begin dec_o.ctrl = CTRL_XOR; dec_o.illegal = 1'b0; end
               {OPC_R_ARITH, 2'b00}: begin dec_o.ctrl = CTRL_ADD; dec_o.illegal = 1'b0; end
               {OPC_R_ARITH, 2'b01}: begin dec_o.ctrl = CTRL_SUB; dec_o.illegal = 1'b0; end
               {OPC_R_SHIFT, 2'b00}: begin
                  dec_o.ctrl = CTRL_SLL; dec_o.illegal = 1'b0; dec_o.is_shift = 1'b1;
               end
               {OPC_R_SHIFT, 2'b01}: begin
                  dec_o.ctrl = CTRL_SRA; dec_o.illegal = 1'b0; dec_o.is_shift = 1'b1;
               end
               default: dec_o.illegal = 1'b1;
            endcase
         end
         ALUOP_I: begin
            case (opcode)
               OPC_ADDI: begin dec_o.ctrl = CTRL_ADDI; dec_o.illegal = 1'b0; end
               OPC_SUBI: begin dec_o.ctrl = CTRL_SUBI; dec_o.illegal = 1'b0; end
               OPC_SLTI: begin dec_o.ctrl = CTRL_SLTI; dec_o.illegal = 1'b0; end
               default:  dec_o.illegal = 1'b1;
            endcase
         end
         default: dec_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered, valid/ready ALU control decoder.
// Input side : in_valid/in_ready with ALUOp, opcode, Funct, shamt.
// Output side: out_valid/out_ready with ALUCtrl, out_illegal, out_last,
//              out_count (shift steps remaining incl. current beat).
// illegal_seen is sticky, cleared by clr_illegal (a new illegal wins).
// With MULTI_SHIFT=1 a shift by N>=2 is expanded into N single-bit beats.
module alu_ctrl_pipe
   import alu_pkg::*;
#(
   parameter int OPC_W       = ALU_OPC_W,
   parameter int FUNCT_W     = ALU_FUNCT_W,
   parameter int CTRL_W      = ALU_CTRL_W,
   parameter int SHAMT_W     = ALU_SHAMT_W,
   parameter int MULTI_SHIFT = 1
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         ALUOp,
   input  logic [OPC_W-1:0]   opcode,
   input  logic [FUNCT_W-1:0] Funct,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               clr_illegal,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  ALUCtrl,
   output logic               out_illegal,
   output logic               out_last,
   output logic [SHAMT_W-1:0] out_count,
   output logic               illegal_seen
);

   state_e               state_q, state_d;
   logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
   logic                 illegal_q, illegal_d;
   logic                 last_q, last_d;
   logic [SHAMT_W-1:0]   count_q, count_d;
   logic                 seen_q, seen_d;
   dec_t                 dec;
   logic                 fire;
   logic                 accept;
   logic                 long_shift;

   alu_ctrl_decode #(.OPC_W(OPC_W), .FUNCT_W(FUNCT_W)) u_decode (
      .ALUOp  (ALUOp),
      .opcode (opcode),
      .Funct  (Funct),
      .dec_o  (dec)
   );

   assign out_valid  = (state_q != ST_IDLE);
   assign fire       = out_valid & out_ready;
   // Accept while idle, or on the same edge the final beat is consumed
   assign in_ready   = (state_q == ST_IDLE) | (fire & last_q);
   assign accept     = in_valid & in_ready;
   assign long_shift = dec.is_shift & (MULTI_SHIFT != 0) & (shamt > SHAMT_W'(1));

   // Next-state, beat contents and sticky illegal flag
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      last_d    = last_q;
      count_d   = count_q;
      seen_d    = seen_q;
      if (accept) begin
         ctrl_d    = dec.ctrl;
         illegal_d = dec.illegal;
         count_d   = dec.is_shift ? shamt : '0;
         state_d   = long_shift ? ST_SHIFT : ST_SINGLE;
         last_d    = ~long_shift;
      end else if (fire) begin
         if (last_q) begin
            state_d   = ST_IDLE;
            ctrl_d    = '0;
            illegal_d = 1'b0;
            last_d    = 1'b0;
            count_d   = '0;
         end else begin
            // Counter starts at shamt>=2 and stops at 1, so it never wraps
            count_d = count_q - SHAMT_W'(1);
            last_d  = (count_q == SHAMT_W'(2));
         end
      end else begin
         state_d = state_q;
      end
      if (accept && dec.illegal) begin
         seen_d = 1'b1;
      end else if (clr_illegal) begin
         seen_d = 1'b0;
      end else begin
         seen_d = seen_q;
      end
   end

   // State and output registers
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
         last_q    <= 1'b0;
         count_q   <= '0;
         seen_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         last_q    <= last_d;
         count_q   <= count_d;
         seen_q    <= seen_d;
      end
   end

   assign ALUCtrl      = ctrl_q;
   assign out_illegal  = illegal_q;
   assign out_last     = last_q;
   assign out_count    = count_q;
   assign illegal_seen = seen_q;

endmodule
